// File: rtl/gpu_pipe_pkg.sv
// Shared helpers for the GPU pipeline blocks.
// Holds width arithmetic used by counters that must hold 0..N inclusive.
package gpu_pipe_pkg;

    function automatic int clog2_plus1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/latency_sink_if.sv
// Valid/ready stream bundle used on the consumer side of latency_sink.
// The master drives valid/data, the slave answers with ready.
interface latency_sink_if #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Circular first-word-fall-through FIFO with a 0..DEPTH count register.
// A read in the same cycle frees a slot for a write even when full.
module sync_fifo_fwft
    import gpu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = clog2_plus1(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rd;
    logic             wr;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd      = rd_en && !empty;
    assign wr      = wr_en && (!full || rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage has no reset; empty forces the visible head to zero.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; count moves only on unbalanced traffic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr && !rd) begin
                count <= count + 1'b1;
            end else if (rd && !wr) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/latency_sink.sv
// Receiving end of a fixed-latency pipe: buffers results and hands out
// issue credits so every launched operation has a slot when it lands.
module latency_sink
    import gpu_pipe_pkg::*;
#(
    parameter int LATENCY = 5,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic                          pipe_valid,
    input  logic [WIDTH-1:0]              pipe_data,
    latency_sink_if.master                out,
    output logic [clog2_plus1(DEPTH)-1:0] credits,
    output logic                          overflow
);
    localparam int CW = clog2_plus1(DEPTH);

    if (LATENCY < 1) begin : g_bad_latency
        $error("latency_sink: LATENCY must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("latency_sink: DEPTH must be a power of two >= 2");
    end

    logic fifo_full;
    logic fifo_empty;
    logic issue_fire;
    logic out_fire;

    sync_fifo_fwft #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pipe_valid),
        .wr_data (pipe_data),
        .rd_en   (out.ready),
        .rd_data (out.data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out.valid   = !fifo_empty;
    assign out_fire    = out.valid && out.ready;
    assign issue_ready = (credits != '0);
    assign issue_fire  = issue_valid && issue_ready;

    // Credit pool: issue takes one, output returns one; held at DEPTH
    // so stray results after a reset cannot inflate the pool.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits <= CW'(DEPTH);
        end else if (issue_fire && !out_fire) begin
            credits <= credits - 1'b1;
        end else if (out_fire && !issue_fire && credits != CW'(DEPTH)) begin
            credits <= credits + 1'b1;
        end
    end

    // Sticky flag for a result that found no room and was dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (pipe_valid && fifo_full && !out_fire) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_latency_sink.sv
// Directed bench for latency_sink: a vector table for per-cycle behaviour
// plus hand-written backpressure, full, overflow and async-reset sequences.
module tb_latency_sink;
    localparam int LAT   = 5;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    typedef struct {
        logic       iv;
        logic       pv;
        logic [7:0] pd;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [3:0] e_cr;
        logic       e_ir;
        logic       e_of;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_ready;
    logic       pipe_valid;
    logic [7:0] pipe_data;
    logic [3:0] credits;
    logic       overflow;

    logic       model_en;
    logic       tb_pv;
    logic [7:0] tb_pd;

    logic [LAT-1:0] mv;
    logic [7:0]     md [LAT];
    logic [7:0]     seq;

    int nvec  = 0;
    int nfail = 0;

    vec_t tbl [20];

    latency_sink_if #(.WIDTH(WIDTH)) out_if ();

    latency_sink #(
        .LATENCY (LAT),
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .pipe_valid  (pipe_valid),
        .pipe_data   (pipe_data),
        .out         (out_if),
        .credits     (credits),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Bench pipe: issue fires emerge LAT cycles later with a sequence tag.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mv  <= '0;
            seq <= '0;
            for (int i = 0; i < LAT; i++) md[i] <= '0;
        end else begin
            mv    <= {mv[LAT-2:0], issue_valid && issue_ready};
            md[0] <= seq;
            for (int i = 1; i < LAT; i++) md[i] <= md[i-1];
            if (issue_valid && issue_ready) seq <= seq + 8'd1;
        end
    end

    assign pipe_valid = model_en ? mv[LAT-1] : tb_pv;
    assign pipe_data  = model_en ? md[LAT-1] : tb_pd;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        tb_pv        = 1'b0;
        tb_pd        = 8'h00;
        out_if.ready = 1'b0;
        model_en     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic run_table();
        for (int i = 0; i < 20; i++) begin
            issue_valid  = tbl[i].iv;
            tb_pv        = tbl[i].pv;
            tb_pd        = tbl[i].pd;
            out_if.ready = tbl[i].ordy;
            cyc();
            chk($sformatf("vec[%0d]", i),
                {17'd0, out_if.valid, out_if.data, credits, issue_ready,
                 overflow},
                {17'd0, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_cr, tbl[i].e_ir,
                 tbl[i].e_of});
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Single issue, result 5 cycles later, then a same-cycle
        // issue plus output fire that leaves credits unchanged.
        for (int i = 0; i < 20; i++)
            tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd7, 1'b1, 1'b0};
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd7, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 4'd7, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd8, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd7, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 4'd7, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd7, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 8'h6B, 1'b1, 1'b1, 8'h6B, 4'd7, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd8, 1'b1, 1'b0};

        idle_inputs();
        reset = 1'b0;
        cyc();
        chk("rst_hold", {credits, issue_ready, out_if.valid, out_if.data,
                         overflow}, {4'd8, 1'b1, 1'b0, 8'h00, 1'b0});
        reset = 1'b1;
        cyc();
        chk("rst_release", {credits, issue_ready, out_if.valid, out_if.data,
                            overflow}, {4'd8, 1'b1, 1'b0, 8'h00, 1'b0});

        run_table();

        // Backpressure: 12 cycles of issue_valid, only 8 credits.
        do_reset();
        model_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue_valid = 1'b1;
            chk($sformatf("bp_ready[%0d]", i), issue_ready, (i < 8));
            cyc();
        end
        issue_valid = 1'b0;
        repeat (3) cyc();
        chk("bp_full", {credits, out_if.valid, out_if.data, overflow},
            {4'd0, 1'b1, 8'h00, 1'b0});
        out_if.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_drain[%0d]", k), {out_if.valid, out_if.data},
                {1'b1, 8'(k)});
            cyc();
        end
        chk("bp_empty", {out_if.valid, out_if.data, credits, issue_ready},
            {1'b0, 8'h00, 4'd8, 1'b1});
        idle_inputs();

        // Credits exhausted: output fire returns a credit one cycle late.
        do_reset();
        model_en = 1'b1;
        issue_valid = 1'b1;
        repeat (8) cyc();
        issue_valid = 1'b0;
        repeat (6) cyc();
        chk("cr_full", {credits, issue_ready, out_if.valid, out_if.data},
            {4'd0, 1'b0, 1'b1, 8'h00});
        out_if.ready = 1'b1;
        issue_valid  = 1'b1;
        chk("cr_same", issue_ready, 1'b0);
        cyc();
        out_if.ready = 1'b0;
        chk("cr_next", {credits, issue_ready, out_if.data},
            {4'd1, 1'b1, 8'h01});
        cyc();
        issue_valid = 1'b0;
        chk("cr_taken", {credits, issue_ready}, {4'd0, 1'b0});
        repeat (6) cyc();
        chk("fs_full", {out_if.valid, out_if.data}, {1'b1, 8'h01});

        // Full buffer: read head and write new entry in one cycle.
        model_en     = 1'b0;
        tb_pv        = 1'b1;
        tb_pd        = 8'h55;
        out_if.ready = 1'b1;
        cyc();
        tb_pv        = 1'b0;
        out_if.ready = 1'b0;
        chk("fs_both", {out_if.valid, out_if.data, overflow},
            {1'b1, 8'h02, 1'b0});
        out_if.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fs_drain[%0d]", k), {out_if.valid, out_if.data},
                {1'b1, (k < 7) ? 8'(k + 2) : 8'h55});
            cyc();
        end
        chk("fs_empty", {out_if.valid, out_if.data, overflow},
            {1'b0, 8'h00, 1'b0});
        idle_inputs();

        // Overflow: 9 forced results into 8 slots with no reads.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tb_pv = 1'b1;
            tb_pd = 8'h30 + 8'(i);
            cyc();
            chk($sformatf("ovf[%0d]", i), overflow, (i == 8));
        end
        tb_pv = 1'b0;
        repeat (2) cyc();
        chk("ovf_sticky", overflow, 1'b1);
        out_if.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_drain[%0d]", k), {out_if.valid, out_if.data},
                {1'b1, 8'h30 + 8'(k)});
            cyc();
        end
        chk("ovf_after", {out_if.valid, out_if.data, overflow},
            {1'b0, 8'h00, 1'b1});
        idle_inputs();

        // Async reset with 3 entries stored, no clock edge needed.
        model_en    = 1'b1;
        issue_valid = 1'b1;
        repeat (3) cyc();
        issue_valid = 1'b0;
        repeat (6) cyc();
        chk("ar_before", {out_if.valid, out_if.data}, {1'b1, 8'h00});
        #1;
        reset = 1'b0;
        #2;
        chk("ar_async", {out_if.valid, out_if.data, credits, issue_ready,
                         overflow}, {1'b0, 8'h00, 4'd8, 1'b1, 1'b0});
        #3;
        reset    = 1'b1;
        model_en = 1'b0;
        cyc();

        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/latency_sink.md
Name: latency_sink

Overview:
- Receiving end of a fixed-latency pipeline, such as a delay line of flip-flops or a BRAM read path.
- Buffers results leaving the pipe and presents them on a valid/ready output, so a stalled consumer loses nothing.
- Tracks credits: the issuer may start an operation only when a buffer slot is guaranteed free by the time its result emerges LATENCY cycles later.
- Sits between a fixed-latency datapath stage and any backpressured consumer, e.g. the pixel writer or framebuffer stage.

Parameters:
- LATENCY, 5: cycles from issue to pipe_valid at this block; informational only, used by the bench; must be >= 1.
- WIDTH, 8: data width.
- DEPTH, 8: buffer entries, and also the total credits; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; assertion clears state immediately, deassertion is synchronised externally.
- issue_valid  in  1  upstream wants to launch an operation into the pipe this cycle.
- issue_ready  out  1  a credit is available; an issue fires when issue_valid && issue_ready.
- pipe_valid  in  1  result valid at the pipe output.
- pipe_data  in  WIDTH  result data.
- out_valid  out  1  buffer head is valid.
- out_data  out  WIDTH  buffer head data, first-word-fall-through.
- out_ready  in  1  consumer accepts; an output fires when out_valid && out_ready.
- credits  out  $clog2(DEPTH+1)  free credits = DEPTH − (in-flight + stored).
- overflow  out  1  sticky error flag.

Behaviour:

Reset values (while reset is low):
- credits=DEPTH, issue_ready=1.
- out_valid=0, out_data=0.
- overflow=0.
- Read/write pointers and count = 0; memory contents are don't-care, but out_data is forced to 0 whenever count=0.

Credit counter:
- Issue fire: −1. Output fire: +1. Both in the same cycle: unchanged.
- issue_ready = (credits != 0), driven combinationally from the registered counter.
- An output fire in cycle N makes issue_ready visible in cycle N+1, never the same cycle. There is no combinational path from out_ready to issue_ready.
- Credits never exceed DEPTH and never go below 0 under legal use.

Buffer:
- Circular, DEPTH entries, pointers wrap modulo DEPTH, plus a count register holding 0..DEPTH.
- Write when pipe_valid is high and the buffer is not full.
- Read on an output fire.
- out_valid = (count != 0); out_data = mem[rd_ptr].
- Write latency: pipe_valid sampled at edge N gives out_valid high from edge N until the entry is read. Minimum input-to-output latency is 1 cycle; there is no bypass path.
- Simultaneous read and write:
  - When count>0, count is unchanged.
  - When count==0, the write lands and no read occurs, because out_valid was 0.
  - When count==DEPTH, the read frees a slot and the write is still accepted in the same cycle; the full check uses count minus the read.

Overflow:
- pipe_valid while the buffer is full and no read is occurring sets overflow=1 and drops the data.
- overflow holds until reset.
- This is unreachable when the issuer honours issue_ready.

Ordering and illegal input:
- Output order is strictly the pipe_valid order.
- issue_valid while issue_ready=0 is ignored: no credit change, no error.
- Reset asserted mid-operation discards everything in flight. The issuer must also flush the pipe; results arriving after reset deassertion are buffered normally without credit accounting. This is a system constraint, and the bench holds the pipe in reset alongside this block.

Arithmetic:
- Counter widths are $clog2(DEPTH+1).
- Pointers are $clog2(DEPTH) bits, wrapping naturally.

Decomposition:
- Shared package gpu_pipe_pkg holds the function clog2_plus1(n) used for counter widths.
- No typedefs are needed.
- Sub-module: sync_fifo_fwft, covering storage, pointers, count, full/empty and FWFT read, with the same clk/reset convention.
- latency_sink adds the credit counter and overflow logic around it.

Test Plan:
- Reset release: credits=8, issue_ready=1, out_valid=0, out_data=0, overflow=0.
- Single issue with bench delay of 5 cycles, out_ready=1:
  - credits drops to 7 after the issue edge.
  - pipe_valid with data 0xA5 arrives 5 cycles later.
  - out_valid=1 with out_data=0xA5 for one cycle.
  - credits returns to 8 on the next cycle.
- Backpressure: out_ready=0, issue_valid held high for 12 cycles.
  - Exactly 8 issues fire, issue_ready falls after the 8th.
  - 8 results are buffered in order 0..7, overflow=0.
  - Raising out_ready drains 0..7 in order, one per cycle.
- Full and simultaneous:
  - With the buffer full, out_ready=1 and pipe_valid the same cycle: the read of the head and the write of the new entry both succeed, and count stays 8.
  - With credits=0, an output fire plus issue_valid in the same cycle: the issue fires only on the next cycle.
- Overflow injection: bench forces 9 pipe_valid pulses with out_ready=0 and no issues.
  - overflow=1 after the 9th pulse and stays set; the 9th datum is never output.
- Async reset mid-burst: reset low for half a cycle with 3 entries stored.
  - out_valid=0 and credits=8 immediately, without waiting for a clock edge.
  - After release, new traffic behaves as in the single-issue scenario.
